// File: rtl/ppc_enc_pkg.sv
// rtl/ppc_enc_pkg.sv - shared constants, output-stage states and helpers for the PPC request encoders
package ppc_enc_pkg;

    localparam int ENC_N = 8;
    localparam int ENC_W = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } out_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Big-endian request vectors sometimes need handing to little-endian consumers
    function automatic logic [0:ENC_N-1] bit_reverse(input logic [0:ENC_N-1] v);
        logic [0:ENC_N-1] r;
        for (int i = 0; i < ENC_N; i++) begin
            r[i] = v[ENC_N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pri_enc_ffs.sv
// rtl/pri_enc_ffs.sv - combinational find-first-set over a big-endian vector, lowest index wins
module pri_enc_ffs #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [0:N-1] vec,
    output logic [0:W-1] idx,
    output logic         any
);

    // Scan from the low-priority end so the lowest-numbered set bit is written last
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder8to3_pend.sv
// rtl/encoder8to3_pend.sv - sticky pending register with registered priority code under valid/ack
module encoder8to3_pend
    import ppc_enc_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:N-1] req,
    input  logic [0:N-1] mask,
    input  logic         ack,
    input  logic         flush,
    output logic         valid,
    output logic [0:W-1] code,
    output logic [0:N-1] pend
);

    out_state_e   state_q, state_d;
    logic [0:N-1] pend_q, pend_d;
    logic [0:W-1] code_q, code_d;
    logic [0:N-1] clr;
    logic [0:N-1] cand;
    logic [0:W-1] ffs_idx;
    logic         ffs_any;
    logic         present;
    logic         load;

    assign present = (state_q == ST_PRESENT);
    assign load    = ~present | ack;

    always_comb begin
        clr = '0;
        if (present && ack) begin
            clr[code_q] = 1'b1;
        end
    end

    // Requests arriving this cycle are excluded from selection; they only reach pend
    assign cand = pend_q & ~clr & mask;

    pri_enc_ffs #(
        .N (N),
        .W (W)
    ) u_ffs (
        .vec (cand),
        .idx (ffs_idx),
        .any (ffs_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pend_d  = (pend_q & ~clr) | req;
        if (flush) begin
            state_d = ST_IDLE;
            code_d  = '0;
            pend_d  = '0;
        end else if (load) begin
            state_d = ffs_any ? ST_PRESENT : ST_IDLE;
            code_d  = ffs_any ? ffs_idx : '0;
        end
    end

    always_comb begin
        valid = present;
        code  = code_q;
        pend  = pend_q;
    end

endmodule

// File: tb/tb_encoder8to3_pend.sv
// tb/tb_encoder8to3_pend.sv - scoreboard bench with behavioural model for encoder8to3_pend
module tb_encoder8to3_pend;

    localparam int N = 8;
    localparam int W = 3;

    typedef struct {
        logic [0:N-1] pend;
        logic         valid;
        logic [0:W-1] code;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [0:N-1] req;
    logic [0:N-1] mask;
    logic         ack;
    logic         flush;
    logic         valid;
    logic [0:W-1] code;
    logic [0:N-1] pend;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    logic [0:N-1] m_pend;
    logic         m_valid;
    int           m_code;

    encoder8to3_pend dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .mask  (mask),
        .ack   (ack),
        .flush (flush),
        .valid (valid),
        .code  (code),
        .pend  (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_code  = 0;
    endtask

    // Apply one cycle of the rules to the model and queue the expected post-edge state
    task automatic model_step(input logic [0:N-1] r, input logic [0:N-1] m,
                              input logic a, input logic f);
        int           clr_idx;
        int           pick;
        logic [0:N-1] np;
        exp_t         e;
        if (f) begin
            model_reset();
        end else begin
            clr_idx = (m_valid && a) ? m_code : -1;
            for (int i = 0; i < N; i++) begin
                np[i] = (m_pend[i] && i != clr_idx) || r[i];
            end
            if (!m_valid || a) begin
                pick = -1;
                for (int i = 0; i < N; i++) begin
                    if (pick < 0 && m_pend[i] && i != clr_idx && m[i]) pick = i;
                end
                m_valid = (pick >= 0);
                m_code  = (pick >= 0) ? pick : 0;
            end
            m_pend = np;
        end
        e.pend  = m_pend;
        e.valid = m_valid;
        e.code  = W'(m_code);
        sb.push_back(e);
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic step(input logic [0:N-1] r, input logic [0:N-1] m,
                        input logic a, input logic f);
        req   = r;
        mask  = m;
        ack   = a;
        flush = f;
        model_step(r, m, a, f);
        @(negedge clk);
    endtask

    task automatic async_reset();
        req   = '0;
        ack   = 1'b0;
        flush = 1'b0;
        model_step('0, mask, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_pend", 32'(pend), 32'h0);
        chk("async_rst_valid", 32'(valid), 32'h0);
        chk("async_rst_code", 32'(code), 32'h0);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_pend", 32'(pend), 32'(e.pend));
            chk("sb_valid", 32'(valid), 32'(e.valid));
            if (e.valid) chk("sb_code", 32'(code), 32'(e.code));
            else         chk("sb_code_idle", 32'(code), 32'h0);
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = '0;
        mask     = 8'hFF;
        ack      = 1'b0;
        flush    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_pend", 32'(pend), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_code", 32'(code), 32'h0);
        rst = 1'b0;

        // Single source, bit 5
        step(8'h04, 8'hFF, 1'b0, 1'b0);
        chk("single_pend_t1", 32'(pend), 32'h04);
        chk("single_valid_t1", 32'(valid), 32'h0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("single_valid_t2", 32'(valid), 32'h1);
        chk("single_code_t2", 32'(code), 32'd5);
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        chk("single_pend_t3", 32'(pend), 32'h00);
        chk("single_valid_t3", 32'(valid), 32'h0);

        // Priority and back-to-back retire
        step(8'h81, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("prio_code0", 32'(code), 32'd0);
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        chk("b2b_valid", 32'(valid), 32'h1);
        chk("b2b_code7", 32'(code), 32'd7);
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        chk("b2b_done", 32'(valid), 32'h0);

        // Masking and stability of a presented code
        step(8'h22, 8'hDF, 1'b0, 1'b0);
        step(8'h00, 8'hDF, 1'b0, 1'b0);
        chk("mask_code6", 32'(code), 32'd6);
        step(8'h00, 8'hDD, 1'b0, 1'b0);
        chk("mask_hold_valid", 32'(valid), 32'h1);
        chk("mask_hold_code6", 32'(code), 32'd6);
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        chk("mask_then_code2", 32'(code), 32'd2);
        step(8'h00, 8'hFF, 1'b1, 1'b0);

        // Ack colliding with a re-request of the same bit
        step(8'h10, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("coll_code3", 32'(code), 32'd3);
        step(8'h10, 8'hFF, 1'b1, 1'b0);
        chk("coll_pend_kept", 32'(pend), 32'h10);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("coll_represent_valid", 32'(valid), 32'h1);
        chk("coll_represent_code", 32'(code), 32'd3);
        step(8'h00, 8'hFF, 1'b1, 1'b0);

        // Flush beats ack and req
        step(8'h3C, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("flush_pre_valid", 32'(valid), 32'h1);
        step(8'h01, 8'hFF, 1'b1, 1'b1);
        chk("flush_pend", 32'(pend), 32'h0);
        chk("flush_valid", 32'(valid), 32'h0);
        chk("flush_code", 32'(code), 32'h0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("flush_req_dropped", 32'(pend), 32'h0);

        // Asynchronous reset with everything pending
        step(8'hFF, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("pre_rst_pend", 32'(pend), 32'hFF);
        chk("pre_rst_valid", 32'(valid), 32'h1);
        async_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [0:N-1] r;
            logic [0:N-1] m;
            r = ($urandom_range(0, 3) == 0) ? N'($urandom) & N'($urandom) : '0;
            m = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
            step(r, m, 1'($urandom_range(0, 1)), ($urandom_range(0, 60) == 0));
            if (i % 997 == 500) async_reset();
        end
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
